op_packer: RTL and testbench
============================

OP_PACKER -- requirements
Module: op_packer

Interface
REQ-001 SHALL have parameter TERMS, default 12: number of operand terms per packed vector.
REQ-002 SHALL have parameter WIDTH, default 4: bits per term; 3 and 4 are the supported values.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  term on in_data is offered.
REQ-006 SHALL have port in_ready  output  1  block accepts a term this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  weight term.
REQ-008 SHALL have port in_mask  input  1  gate bit; an accepted term is stored as zero when in_mask is 0.
REQ-009 SHALL have port in_abort  input  1  discard the partially or fully assembled vector.
REQ-010 SHALL have port out_valid  output  1  out_op holds a complete vector.
REQ-011 SHALL have port out_ready  input  1  consumer (sum tree) takes the vector this cycle.
REQ-012 SHALL have port out_op  output  TERMS*WIDTH  packed operand vector for the Wallace sum tree.

Function
REQ-013 SHALL accept a term on each cycle where in_valid and in_ready are both high.
REQ-014 SHALL store accepted term k (k = 0..TERMS-1, in arrival order) at out_op[k*WIDTH +: WIDTH], with term 0 in the LSBs.
REQ-015 SHALL implement two states:
- FILL: in_ready=1.
- FULL: in_ready=0; the assembled vector waits for the output slot.
REQ-016 SHALL keep a fill counter 0..TERMS-1 that wraps to 0 after term TERMS-1 is accepted.
REQ-017 SHALL transfer the vector to the output register on the edge that accepts term TERMS-1, provided the slot is free, and stay in FILL; the slot is free when out_valid=0 or out_ready=1 that cycle.
REQ-018 SHALL enter FULL if the slot is not free on that edge.
REQ-019 SHALL, while in FULL, transfer the vector on the first edge the slot is free and then return to FILL with count 0.
REQ-020 SHALL set out_valid on transfer and clear it on out_ready only when no new transfer occurs on the same edge.
REQ-021 SHALL hold out_op stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain one vector per TERMS cycles with no bubble while in_valid and out_ready stay high.
REQ-023 SHALL make in_abort clear the count and the assembly buffer and return to FILL; the output register is unaffected.
REQ-024 SHALL give in_abort priority over a simultaneous term acceptance (that term is dropped) and over a simultaneous FULL-to-output transfer (the vector is discarded).
REQ-025 SHALL have no combinational path from in_valid or in_data to any output; in_ready depends on state only.

Reset
REQ-026 SHALL, on rst_n low, immediately force state=FILL, count=0, out_valid=0, out_op=0, assembly buffer=0 (and out_sum=0 when enabled).
REQ-027 SHALL drop any partial or held vector on reset mid-operation; the first term after reset release is term 0.

Configuration
REQ-028 SHALL, when macro OP_PACKER_SUM_EN is defined:
- add output port out_sum, width WIDTH+4;
- accumulate out_sum sequentially from the gated terms;
- register out_sum alongside out_op, valid under out_valid, with the same stability rule as out_op.
REQ-029 SHALL, when OP_PACKER_SUM_EN is undefined, omit the out_sum port and its accumulator entirely, with behaviour otherwise identical.

Structure
REQ-030 SHALL take TERMS and WIDTH defaults and the state enumeration from the shared package perceptron_pkg.
REQ-031 SHALL be a single module; no sub-module is needed.

Verification
REQ-032 SHALL cover basic packing: 12 terms 1..12, mask all 1, out_ready=1 -> out_op[3:0]=1, out_op[47:44]=12, out_valid high 1 cycle after the 12th accept; out_sum=78 when enabled.
REQ-033 SHALL cover masking: terms all 15, mask alternating 1,0 starting with 1 -> even terms 15, odd terms 0; out_sum=90 when enabled.
REQ-034 SHALL cover backpressure: out_ready=0 with two vectors streamed -> second vector enters FULL with in_ready=0 and first out_op stable; out_ready=1 for one cycle -> second vector loads, in_ready returns to 1 on the next cycle.
REQ-035 SHALL cover abort: abort asserted with the 5th term -> that term is dropped; the next 12 terms form the vector, with term 0 = the first term after abort.
REQ-036 SHALL cover async reset: rst_n pulsed low mid-fill and during FULL -> out_valid=0 immediately, in_ready=1, count restarts at 0.
REQ-037 SHALL cover throughput: continuous in_valid and out_ready for 120 cycles -> exactly 10 vectors, none lost or duplicated.

Source files
------------

// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared defaults and state encoding for the operand packer.
package perceptron_pkg;
  localparam int TERMS_DEF = 12;
  localparam int WIDTH_DEF = 4;
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} pk_state_e;
endpackage

// File: rtl/op_packer_if.sv
// op_packer_if: term stream in, packed operand vector out; out_sum exists only with OP_PACKER_SUM_EN.
interface op_packer_if import perceptron_pkg::*; #(
  parameter int TERMS = TERMS_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   in_mask;
  logic                   in_abort;
  logic                   out_valid;
  logic                   out_ready;
  logic [TERMS*WIDTH-1:0] out_op;
`ifdef OP_PACKER_SUM_EN
  logic [WIDTH+3:0]       out_sum;
  modport master (output in_valid, in_data, in_mask, in_abort, out_ready,
                  input  in_ready, out_valid, out_op, out_sum);
  modport slave  (input  in_valid, in_data, in_mask, in_abort, out_ready,
                  output in_ready, out_valid, out_op, out_sum);
`else
  modport master (output in_valid, in_data, in_mask, in_abort, out_ready,
                  input  in_ready, out_valid, out_op);
  modport slave  (input  in_valid, in_data, in_mask, in_abort, out_ready,
                  output in_ready, out_valid, out_op);
`endif
endinterface

// File: rtl/op_packer.sv
// op_packer: gathers TERMS gated terms into one vector for the sum tree, with a one-deep output slot.
// OP_PACKER_SUM_EN adds a registered running sum of the gated terms (out_sum).
module op_packer import perceptron_pkg::*; #(
  parameter int TERMS = TERMS_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input logic       clk,
  input logic       rst_n,
  op_packer_if.slave bus
);
  localparam int CW = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam int VW = TERMS * WIDTH;
  pk_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [VW-1:0]  buf_q, buf_d, op_q, op_d, fill_vec;
  logic           ov_q, ov_d;
  logic [WIDTH-1:0] term;
  logic           acc, last, slot_free, xfer;
`ifdef OP_PACKER_SUM_EN
  localparam int SW = WIDTH + 4;
  logic [SW-1:0]  sum_q, sum_d, osum_q, osum_d, fill_sum;
`endif
  always_comb begin
    term      = bus.in_mask ? bus.in_data : '0;
    acc       = bus.in_valid && (state_q == FILL);
    last      = acc && (cnt_q == CW'(TERMS - 1));
    slot_free = !ov_q || bus.out_ready;
    fill_vec  = buf_q;
    fill_vec[cnt_q*WIDTH +: WIDTH] = term;
    // abort wins over both a pending FULL transfer and the completing term
    xfer      = !bus.in_abort && slot_free && ((state_q == FULL) || last);
    op_d      = xfer ? ((state_q == FULL) ? buf_q : fill_vec) : op_q;
    ov_d      = xfer || (ov_q && !bus.out_ready);
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    if (bus.in_abort) begin
      state_d = FILL;
      cnt_d   = '0;
      buf_d   = '0;
    end else if (state_q == FULL) begin
      state_d = slot_free ? FILL : FULL;
    end else if (acc) begin
      buf_d   = fill_vec;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      state_d = (last && !slot_free) ? FULL : FILL;
    end
  end
`ifdef OP_PACKER_SUM_EN
  always_comb begin
    fill_sum = sum_q + SW'(term);
    osum_d   = xfer ? ((state_q == FULL) ? sum_q : fill_sum) : osum_q;
    sum_d    = sum_q;
    if (bus.in_abort || xfer) sum_d = '0;
    else if (acc) sum_d = fill_sum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      osum_q <= '0;
    end else begin
      sum_q  <= sum_d;
      osum_q <= osum_d;
    end
  end
  assign bus.out_sum = osum_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
      op_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      op_q    <= op_d;
      ov_q    <= ov_d;
    end
  end
  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = ov_q;
  assign bus.out_op    = op_q;
endmodule

// File: tb/tb_op_packer.sv
// tb_op_packer: directed scenarios plus random traffic against a term-list reference model.
module tb_op_packer;
  import perceptron_pkg::*;
  localparam int T = TERMS_DEF;
  localparam int W = WIDTH_DEF;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  op_packer_if #(.TERMS(T), .WIDTH(W)) bus();
  op_packer #(.TERMS(T), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  int cur[T];
  int n;
  bit held;
  logic [T*W-1:0] held_vec, ovec, saved;
  int held_sum, osum;
  bit ov;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [T*W-1:0] pack_terms();
    logic [T*W-1:0] r = '0;
    for (int k = 0; k < T; k++) r[k*W +: W] = W'(cur[k]);
    return r;
  endfunction
  function automatic int sum_terms();
    int s = 0;
    for (int k = 0; k < T; k++) s += cur[k];
    return s;
  endfunction
  task automatic model_reset();
    n = 0; held = 0; ov = 0; ovec = '0; osum = 0;
    for (int k = 0; k < T; k++) cur[k] = 0;
  endtask
  task automatic model_step(bit v, int d, bit m, bit ab, bit ordy);
    bit free = !ov || ordy;
    bit x = 0;
    logic [T*W-1:0] xv = '0;
    int xs = 0;
    if (ab) begin
      n = 0; held = 0;
      for (int k = 0; k < T; k++) cur[k] = 0;
    end else if (held) begin
      if (free) begin x = 1; xv = held_vec; xs = held_sum; held = 0; end
    end else if (v) begin
      cur[n] = m ? (d & ((1 << W) - 1)) : 0;
      n++;
      if (n == T) begin
        n = 0;
        if (free) begin x = 1; xv = pack_terms(); xs = sum_terms(); end
        else begin held = 1; held_vec = pack_terms(); held_sum = sum_terms(); end
      end
    end
    if (x) begin ov = 1; ovec = xv; osum = xs; end
    else if (ordy) ov = 0;
  endtask
  task automatic compare();
    check("in_ready", 64'(bus.in_ready), 64'(!held));
    check("out_valid", 64'(bus.out_valid), 64'(ov));
    if (ov) check("out_op", 64'(bus.out_op), 64'(ovec));
`ifdef OP_PACKER_SUM_EN
    if (ov) check("out_sum", 64'(bus.out_sum), 64'(osum));
`endif
  endtask
  task automatic drive(bit v, int d, bit m, bit ab, bit ordy);
    bus.in_valid = v; bus.in_data = W'(d); bus.in_mask = m;
    bus.in_abort = ab; bus.out_ready = ordy;
    @(posedge clk);
    model_step(v, d, m, ab, ordy);
    @(negedge clk);
    compare();
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_op", 64'(bus.out_op), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int nv;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_mask = 0; bus.in_abort = 0; bus.out_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    compare();
    check("init_op", 64'(bus.out_op), 64'd0);
    // basic packing
    for (int i = 0; i < T; i++) drive(1, i + 1, 1, 0, 1);
    check("pk_valid", 64'(bus.out_valid), 64'd1);
    check("pk_lo", 64'(bus.out_op[W-1:0]), 64'd1);
    check("pk_hi", 64'(bus.out_op[T*W-1 -: W]), 64'(T));
`ifdef OP_PACKER_SUM_EN
    check("pk_sum", 64'(bus.out_sum), 64'd78);
`endif
    drive(0, 0, 0, 0, 1);
    // masking
    for (int i = 0; i < T; i++) drive(1, 15, (i % 2) == 0, 0, 1);
    check("mask_op", 64'(bus.out_op), 64'h0F0F_0F0F_0F0F);
`ifdef OP_PACKER_SUM_EN
    check("mask_sum", 64'(bus.out_sum), 64'd90);
`endif
    drive(0, 0, 0, 0, 1);
    // backpressure
    for (int i = 0; i < 2 * T; i++) begin
      drive(1, $urandom, 1, 0, 0);
      if (i == T - 1) saved = bus.out_op;
    end
    check("bp_ready", 64'(bus.in_ready), 64'd0);
    check("bp_stable", 64'(bus.out_op), 64'(saved));
    repeat (2) drive(1, $urandom, 1, 0, 0);
    check("bp_stable2", 64'(bus.out_op), 64'(saved));
    drive(0, 0, 0, 0, 1);
    check("bp_ready_back", 64'(bus.in_ready), 64'd1);
    drive(0, 0, 0, 0, 1);
    // abort with the 5th term
    for (int i = 0; i < 4; i++) drive(1, i + 1, 1, 0, 1);
    drive(1, 5, 1, 1, 1);
    for (int i = 0; i < T; i++) drive(1, i + 6, 1, 0, 1);
    check("abort_t0", 64'(bus.out_op[W-1:0]), 64'd6);
    drive(0, 0, 0, 0, 1);
    // async reset mid-fill and during FULL
    for (int i = 0; i < 5; i++) drive(1, $urandom, 1, 0, 1);
    async_reset();
    for (int i = 0; i < 2 * T; i++) drive(1, $urandom, 1, 0, 0);
    check("full_before_rst", 64'(bus.in_ready), 64'd0);
    async_reset();
    for (int i = 0; i < T; i++) drive(1, i + 3, 1, 0, 1);
    check("rst_t0", 64'(bus.out_op[W-1:0]), 64'd3);
    async_reset();
    // throughput
    nv = 0;
    for (int i = 0; i < 10 * T; i++) begin
      drive(1, $urandom, $urandom_range(0, 1), 0, 1);
      if (bus.out_valid) nv++;
    end
    check("thru_count", 64'(nv), 64'd10);
    // random traffic
    for (int i = 0; i < 800; i++)
      drive(($urandom % 4) != 0, $urandom, $urandom_range(0, 1), ($urandom % 40) == 0, ($urandom % 3) != 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
